// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the cpu run controller: state encoding, load targets,
// and the dump-window address helper.
package cpu_ctrl_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_DUMP_RD   = 3'd4;
  localparam logic [2:0] ST_DUMP_WAIT = 3'd5;
  localparam logic [2:0] ST_DUMP_OUT  = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_LOAD      = ST_LOAD,
    S_SETTLE    = ST_SETTLE,
    S_RUN       = ST_RUN,
    S_DUMP_RD   = ST_DUMP_RD,
    S_DUMP_WAIT = ST_DUMP_WAIT,
    S_DUMP_OUT  = ST_DUMP_OUT,
    S_DONE      = ST_DONE
  } state_t;

  localparam logic LD_TGT_IMEM = 1'b0;
  localparam logic LD_TGT_DMEM = 1'b1;

  localparam int unsigned WORD_BYTES = 8;

  // Byte address of dump word idx; wraps modulo 2^64 by construction.
  function automatic logic [63:0] dump_word_addr(input logic [63:0] base,
                                                 input logic [31:0] idx);
    return base + ({32'd0, idx} * 64'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/ctrl_down_counter.sv
// Loadable down-counter with a zero flag; used to time the data-memory read latency.
module ctrl_down_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cpu_run_controller.sv
// Host-side sequencer: streams an image into imem/dmem, runs the cpu for a bounded
// number of cycles, then streams a data-memory window back out.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter logic [63:0] DUMP_BASE  = 64'h0,
  parameter int unsigned DUMP_WORDS = 16,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] run_cycles,
  input  logic        halt,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic        ld_target,
  input  logic [63:0] ld_addr,
  input  logic [63:0] ld_data,
  input  logic        ld_last,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [63:0] dump_data,
  output logic [31:0] dump_idx,
  output logic [31:0] cycles_run,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] WAIT_INIT = 32'(RD_LAT - 1);
  localparam logic [31:0] LAST_IDX  = (DUMP_WORDS == 0) ? 32'd0 : 32'(DUMP_WORDS - 1);

  state_t      state;
  logic [31:0] run_lat;
  logic [31:0] run_next;
  logic        enter_dump;
  logic        wait_zero;

  assign run_next = cycles_run + 32'd1;

  // Both the zero-cycle settle path and every RUN exit funnel into the dump path.
  always_comb begin
    enter_dump = 1'b0;
    if (state == S_SETTLE && run_lat == '0)
      enter_dump = 1'b1;
    if (state == S_RUN && (halt || run_next == run_lat))
      enter_dump = 1'b1;
  end

  ctrl_down_counter #(.W(32)) u_wait (
    .clk      (clk),
    .arst     (arst),
    .load     (state == S_DUMP_RD),
    .load_val (WAIT_INIT),
    .dec      (state == S_DUMP_WAIT),
    .zero     (wait_zero)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= S_IDLE;
      run_lat     <= '0;
      ld_ready    <= 1'b0;
      cpu_enable  <= 1'b0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      ren_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      dump_valid  <= 1'b0;
      dump_data   <= '0;
      dump_idx    <= '0;
      cycles_run  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort) begin
      // Any word accepted this cycle is dropped: no strobe follows an abort.
      state      <= S_IDLE;
      ld_ready   <= 1'b0;
      cpu_enable <= 1'b0;
      wen_ext    <= 1'b0;
      wen_ext_2  <= 1'b0;
      ren_ext_2  <= 1'b0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LOAD;
            run_lat    <= run_cycles;
            cycles_run <= '0;
            dump_idx   <= '0;
            ld_ready   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_LOAD: begin
          if (ld_valid && ld_ready) begin
            if (ld_target == LD_TGT_IMEM) begin
              wen_ext   <= 1'b1;
              addr_ext  <= ld_addr;
              wdata_ext <= ld_data[31:0];
            end else begin
              wen_ext_2   <= 1'b1;
              addr_ext_2  <= ld_addr;
              wdata_ext_2 <= ld_data;
            end
            if (ld_last) begin
              state    <= S_SETTLE;
              ld_ready <= 1'b0;
            end
          end
        end
        S_SETTLE: begin
          if (run_lat != '0) begin
            state      <= S_RUN;
            cpu_enable <= 1'b1;
          end
        end
        S_RUN: begin
          if (!halt)
            cycles_run <= run_next;
          if (enter_dump)
            cpu_enable <= 1'b0;
        end
        S_DUMP_RD: begin
          state <= S_DUMP_WAIT;
        end
        S_DUMP_WAIT: begin
          if (wait_zero) begin
            state      <= S_DUMP_OUT;
            dump_data  <= rdata_ext_2;
            dump_valid <= 1'b1;
            ren_ext_2  <= 1'b0;
          end
        end
        S_DUMP_OUT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (dump_idx == LAST_IDX) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= S_DUMP_RD;
              dump_idx   <= dump_idx + 32'd1;
              addr_ext_2 <= dump_word_addr(DUMP_BASE, dump_idx + 32'd1);
              ren_ext_2  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (enter_dump) begin
        if (DUMP_WORDS == 0) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state      <= S_DUMP_RD;
          addr_ext_2 <= dump_word_addr(DUMP_BASE, dump_idx);
          ren_ext_2  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed sessions plus randomized load/run/dump
// sessions checked against a word-level reference of memory and run counts.
module tb_cpu_run_controller;
  import cpu_ctrl_pkg::*;

  localparam logic [63:0] BASE = 64'h0;
  localparam int NW  = 4;
  localparam int RDL = 2;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 0, start0 = 0, abort = 0, halt = 0;
  logic [31:0] run_cycles = 0;
  logic        ld_valid = 0, ld_target = 0, ld_last = 0, dump_ready = 0;
  logic [63:0] ld_addr = 0, ld_data = 0;
  logic [63:0] rdata_ext_2;

  logic        ld_ready, cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, dump_data;
  logic [31:0] wdata_ext, dump_idx, cycles_run;
  logic        dump_valid, busy, done;

  logic        z_ld_ready, z_cpu_enable, z_wen_ext, z_ren_ext, z_wen_ext_2, z_ren_ext_2;
  logic [63:0] z_addr_ext, z_addr_ext_2, z_wdata_ext_2, z_dump_data;
  logic [31:0] z_wdata_ext, z_dump_idx, z_cycles_run;
  logic        z_dump_valid, z_busy, z_done;

  cpu_run_controller #(.DUMP_BASE(BASE), .DUMP_WORDS(NW), .RD_LAT(RDL)) u_dut (
    .clk(clk), .arst(arst), .start(start), .abort(abort), .run_cycles(run_cycles),
    .halt(halt), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_target(ld_target),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_idx(dump_idx),
    .cycles_run(cycles_run), .busy(busy), .done(done));

  // Second instance exercises the no-dump configuration.
  cpu_run_controller #(.DUMP_BASE(BASE), .DUMP_WORDS(0), .RD_LAT(1)) u_dut0 (
    .clk(clk), .arst(arst), .start(start0), .abort(abort), .run_cycles(run_cycles),
    .halt(halt), .ld_valid(ld_valid), .ld_ready(z_ld_ready), .ld_target(ld_target),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .cpu_enable(z_cpu_enable),
    .addr_ext(z_addr_ext), .wen_ext(z_wen_ext), .ren_ext(z_ren_ext), .wdata_ext(z_wdata_ext),
    .addr_ext_2(z_addr_ext_2), .wen_ext_2(z_wen_ext_2), .ren_ext_2(z_ren_ext_2),
    .wdata_ext_2(z_wdata_ext_2), .rdata_ext_2(rdata_ext_2), .dump_valid(z_dump_valid),
    .dump_ready(dump_ready), .dump_data(z_dump_data), .dump_idx(z_dump_idx),
    .cycles_run(z_cycles_run), .busy(z_busy), .done(z_done));

  int total = 0, bad = 0;

  function automatic logic [63:0] init_word(input int i);
    return 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0101;
  endfunction

  // Data-memory model driven only by the DUT's port, with RDL-cycle read latency.
  bit   [63:0] mem [64];
  bit          written [64];
  logic [63:0] rd_pipe [RDL];
  always @(posedge clk) begin
    rd_pipe[0] <= !ren_ext_2 ? 64'hBAD0_BAD0_BAD0_BAD0 :
                  written[addr_ext_2[8:3]] ? mem[addr_ext_2[8:3]] : init_word(int'(addr_ext_2[8:3]));
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rdata_ext_2 = rd_pipe[RDL-1];

  logic [63:0] iaddr_q[$], dq_data[$];
  logic [31:0] idata_q[$], dq_idx[$];
  int wi_cnt = 0, wd_cnt = 0, en_cnt = 0, z_en = 0, z_w = 0;
  bit ren_seen = 0, overlap = 0;

  always @(negedge clk) begin
    if (wen_ext) begin
      iaddr_q.push_back(addr_ext);
      idata_q.push_back(wdata_ext);
      wi_cnt <= wi_cnt + 1;
    end
    if (wen_ext_2) begin
      mem[addr_ext_2[8:3]]     <= wdata_ext_2;
      written[addr_ext_2[8:3]] <= 1'b1;
      wd_cnt <= wd_cnt + 1;
    end
    if (cpu_enable) en_cnt <= en_cnt + 1;
    if (ren_ext || z_ren_ext) ren_seen <= 1'b1;
    if ((wen_ext && cpu_enable) || (z_wen_ext && z_cpu_enable)) overlap <= 1'b1;
    if (dump_valid && dump_ready) begin
      dq_data.push_back(dump_data);
      dq_idx.push_back(dump_idx);
    end
    if (z_cpu_enable) z_en <= z_en + 1;
    if (z_wen_ext || z_wen_ext_2) z_w <= z_w + 1;
  end

  // Reference: word list per session, expected imem writes, expected dmem contents.
  logic        w_tgt[$];
  logic [63:0] w_addr[$], w_data[$];
  logic [63:0] exp_ia[$];
  logic [31:0] exp_id[$];
  logic [63:0] ref_mem [64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, ".ctl"}, 64'({ld_ready, cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2,
                            dump_valid, busy, done}), 64'd0);
    chk({tag, ".addr"}, addr_ext | addr_ext_2, 64'd0);
    chk({tag, ".wdata"}, wdata_ext_2 | 64'(wdata_ext), 64'd0);
    chk({tag, ".dump"}, dump_data | 64'(dump_idx), 64'd0);
    chk({tag, ".cycles"}, 64'(cycles_run), 64'd0);
  endtask

  task automatic add_word(input logic tgt, input logic [63:0] a, input logic [63:0] d);
    w_tgt.push_back(tgt); w_addr.push_back(a); w_data.push_back(d);
  endtask

  task automatic rand_words();
    int n;
    logic t;
    w_tgt.delete(); w_addr.delete(); w_data.delete();
    n = int'($urandom_range(5, 2));
    for (int i = 0; i < n; i++) begin
      t = 1'($urandom_range(1, 0));
      add_word(t, t == LD_TGT_DMEM ? 64'($urandom_range(7, 0)) * 64'd8
                                   : 64'($urandom_range(63, 0)) * 64'd4,
               {$urandom, $urandom});
    end
  endtask

  task automatic send_words(input bit use_z, input bit gaps);
    bit acc;
    int n;
    n = w_tgt.size();
    for (int i = 0; i < n; i++) begin
      ld_valid = 1; ld_target = w_tgt[i]; ld_addr = w_addr[i]; ld_data = w_data[i];
      ld_last = (i == n - 1);
      acc = 0;
      for (int t = 0; t < 20 && !acc; t++) begin
        @(negedge clk); acc = use_z ? z_ld_ready : ld_ready;
        @(posedge clk); #1;
      end
      chk("load.accept", 64'(acc), 64'd1);
      if (!use_z) begin
        if (w_tgt[i] == LD_TGT_IMEM) begin
          exp_ia.push_back(w_addr[i]); exp_id.push_back(w_data[i][31:0]);
        end else ref_mem[w_addr[i][8:3]] = w_data[i];
      end
      if (gaps && i != n - 1 && $urandom_range(1, 0) == 1) begin
        ld_valid = 0; @(posedge clk); #1;
      end
    end
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic session(input logic [31:0] rc, input int halt_at, input bit toggle,
                         input bit gaps, input string tag);
    int bi, bq, be, bw, nd, exp_run, exp_en;
    bit ok;
    bi = iaddr_q.size(); bq = dq_data.size(); be = en_cnt; bw = wd_cnt;
    exp_ia.delete(); exp_id.delete();
    nd = 0;
    foreach (w_tgt[i]) if (w_tgt[i] == LD_TGT_DMEM) nd++;
    run_cycles = rc; start = 1; @(posedge clk); #1; start = 0;
    run_cycles = $urandom;
    chk({tag, ".load_state"}, 64'({busy, ld_ready, done}), 64'b110);
    chk({tag, ".cyc_clr"}, 64'(cycles_run), 64'd0);
    send_words(0, gaps);
    chk({tag, ".settle"}, 64'({ld_ready, busy, cpu_enable}), 64'b010);
    chk({tag, ".last_wr"}, 64'(w_tgt[w_tgt.size()-1] == LD_TGT_IMEM ? wen_ext : wen_ext_2), 64'd1);
    ok = 0; dump_ready = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(posedge clk); #1;
      if (done) ok = 1;
      halt = (halt_at >= 0) && cpu_enable && (en_cnt - be == halt_at);
      dump_ready = toggle ? ~dump_ready : 1'($urandom_range(1, 0));
    end
    halt = 0; dump_ready = 0;
    chk({tag, ".reached_done"}, 64'(ok), 64'd1);
    exp_run = (halt_at >= 0) ? halt_at : int'(rc);
    exp_en  = (halt_at >= 0) ? halt_at + 1 : int'(rc);
    chk({tag, ".cycles_run"}, 64'(cycles_run), 64'(exp_run));
    chk({tag, ".enable_cycles"}, 64'(en_cnt - be), 64'(exp_en));
    chk({tag, ".end_state"}, 64'({busy, done, cpu_enable}), 64'b010);
    chk({tag, ".imem_count"}, 64'(iaddr_q.size() - bi), 64'(exp_ia.size()));
    for (int i = 0; i < exp_ia.size() && bi + i < iaddr_q.size(); i++) begin
      chk({tag, ".imem_addr"}, iaddr_q[bi+i], exp_ia[i]);
      chk({tag, ".imem_data"}, 64'(idata_q[bi+i]), 64'(exp_id[i]));
    end
    chk({tag, ".dmem_count"}, 64'(wd_cnt - bw), 64'(nd));
    chk({tag, ".dump_count"}, 64'(dq_data.size() - bq), 64'(NW));
    for (int i = 0; i < NW && bq + i < dq_data.size(); i++) begin
      chk({tag, ".dump_data"}, dq_data[bq+i], ref_mem[int'(BASE[8:3]) + i]);
      chk({tag, ".dump_idx"}, 64'(dq_idx[bq+i]), 64'(i));
    end
    chk({tag, ".no_ren_no_overlap"}, 64'({ren_seen, overlap}), 64'd0);
  endtask

  initial begin
    int bw, bz, bzw, rc, ha;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    repeat (3) @(posedge clk);
    #1;
    rst_chk("reset");
    @(negedge clk); arst = 0;
    @(posedge clk); #1;

    // Directed image: three imem words then one dmem word, full 20-cycle run.
    w_tgt.delete(); w_addr.delete(); w_data.delete();
    add_word(LD_TGT_IMEM, 64'h0, 64'h0000_0000_0010_0093);
    add_word(LD_TGT_IMEM, 64'h4, 64'h0000_0000_0020_0113);
    add_word(LD_TGT_IMEM, 64'h8, 64'h0000_0000_0030_0193);
    add_word(LD_TGT_DMEM, 64'h10, 64'hDEAD);
    session(32'd20, -1, 1, 0, "full_run");

    // Halt during the eighth enabled cycle.
    w_tgt.delete(); w_addr.delete(); w_data.delete();
    add_word(LD_TGT_IMEM, 64'h20, 64'h1234_5678);
    add_word(LD_TGT_DMEM, 64'h8, 64'hFEED_F00D_0000_0008);
    session(32'd20, 7, 1, 1, "halt7");

    // No-run, no-dump instance: LOAD, SETTLE, DONE with cpu never enabled.
    bw = wi_cnt + wd_cnt; bz = z_en; bzw = z_w;
    w_tgt.delete(); w_addr.delete(); w_data.delete();
    add_word(LD_TGT_IMEM, 64'h0, 64'hAAAA);
    add_word(LD_TGT_IMEM, 64'h4, 64'hBBBB);
    run_cycles = 0; start0 = 1; @(posedge clk); #1; start0 = 0;
    chk("nodump.load", 64'({z_busy, z_ld_ready}), 64'b11);
    send_words(1, 0);
    chk("nodump.settle", 64'({z_busy, z_done, z_ld_ready}), 64'b100);
    @(posedge clk); #1;
    chk("nodump.done", 64'({z_busy, z_done, z_cpu_enable, z_ren_ext_2}), 64'b0100);
    repeat (3) @(posedge clk);
    #1;
    chk("nodump.no_enable", 64'(z_en - bz), 64'd0);
    chk("nodump.writes", 64'(z_w - bzw), 64'd2);
    chk("idle_ignores_ld", 64'(wi_cnt + wd_cnt - bw), 64'd0);

    // Abort mid-LOAD together with an accept: that word must not be written.
    run_cycles = 5; start = 1; @(posedge clk); #1; start = 0;
    bw = wi_cnt + wd_cnt;
    ld_valid = 1; ld_target = LD_TGT_IMEM; ld_addr = 64'h40; ld_data = 64'h1111; ld_last = 0;
    @(posedge clk); #1;
    ld_addr = 64'h44; ld_data = 64'h2222; abort = 1;
    @(posedge clk); #1;
    abort = 0; ld_valid = 0;
    chk("abort.state", 64'({ld_ready, busy, done, wen_ext, wen_ext_2, cpu_enable}), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort.one_write", 64'(wi_cnt + wd_cnt - bw), 64'd1);
    start = 1; abort = 1; @(posedge clk); #1; start = 0; abort = 0;
    chk("abort_beats_start", 64'({busy, ld_ready}), 64'd0);

    // Asynchronous reset while a dump word is being offered.
    w_tgt.delete(); w_addr.delete(); w_data.delete();
    add_word(LD_TGT_DMEM, 64'h18, 64'h0123_4567_89AB_CDEF);
    run_cycles = 2; start = 1; @(posedge clk); #1; start = 0;
    send_words(0, 0);
    dump_ready = 0;
    for (int c = 0; c < 200 && !dump_valid; c++) begin @(posedge clk); #1; end
    chk("arst.reached_dump_out", 64'(dump_valid), 64'd1);
    bw = wi_cnt + wd_cnt;
    #1 arst = 1;
    #1 rst_chk("arst_async");
    repeat (3) @(posedge clk);
    #1;
    rst_chk("arst_hold");
    chk("arst.no_strobes", 64'(wi_cnt + wd_cnt - bw), 64'd0);
    @(negedge clk); arst = 0;
    @(posedge clk); #1;

    // Randomized sessions with gaps, random halts and random dump back-pressure.
    for (int s = 0; s < 4; s++) begin
      rand_words();
      rc = int'($urandom_range(30, 0));
      ha = (rc != 0 && $urandom_range(1, 0) == 1) ? int'($urandom_range(rc - 1, 0)) : -1;
      session(32'(rc), ha, 0, 1, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
